// File: rtl/mbc1_pkg.sv
// Shared types and constants for the MBC1 cartridge mapper.
// Holds the write-filter state enum, the A[15:13] register-region codes
// and the RAM-enable key value.
package mbc1_pkg;

  // Write-strobe filter states
  typedef enum logic [1:0] {
    IDLE,
    LOW,
    ARMED,
    COMMIT
  } wr_state_e;

  // Register regions, decoded from A[15:13]
  localparam logic [2:0] REG_RAMEN   = 3'b000;  // 0000-1FFF
  localparam logic [2:0] REG_ROMBANK = 3'b001;  // 2000-3FFF
  localparam logic [2:0] REG_BANKHI  = 3'b010;  // 4000-5FFF
  localparam logic [2:0] REG_MODE    = 3'b011;  // 6000-7FFF
  localparam logic [2:0] REG_XRAM    = 3'b101;  // A000-BFFF

  // Low nibble that enables external RAM
  localparam logic [3:0] RAM_EN_KEY = 4'hA;

endpackage

// File: rtl/wr_strobe_filter.sv
// Synchronizes the raw active-low cartridge write strobe and filters out
// short glitches. A strobe that stays low for at least MIN_LOW synchronized
// cycles produces exactly one single-cycle commit pulse on its release.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus_nwr    : raw asynchronous write strobe (active low)
//   commit     : registered one-cycle pulse, high while the filter is in COMMIT
module wr_strobe_filter
  import mbc1_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned MIN_LOW     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bus_nwr,
  output logic commit
);

  localparam int unsigned CNT_W = $clog2(MIN_LOW + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   strobe;
  wr_state_e              state;
  logic [CNT_W-1:0]       low_cnt;

  assign strobe = sync[SYNC_STAGES-1];

  // Synchronizer chain and filter FSM; low_cnt counts synchronized-low cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '1;
      state   <= IDLE;
      low_cnt <= '0;
      commit  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus_nwr};
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (!strobe) begin
            state   <= LOW;
            low_cnt <= CNT_W'(1);
          end
        end
        LOW: begin
          if (strobe) begin
            // Released too early: discard as a glitch
            state   <= IDLE;
            low_cnt <= '0;
          end else if (low_cnt >= CNT_W'(MIN_LOW - 1)) begin
            // This cycle is the MIN_LOW-th low sample
            state   <= ARMED;
            low_cnt <= CNT_W'(MIN_LOW);
          end else begin
            low_cnt <= low_cnt + CNT_W'(1);
          end
        end
        ARMED: begin
          // Holds here for as long as the strobe stays low
          if (strobe) begin
            state   <= COMMIT;
            commit  <= 1'b1;
            low_cnt <= '0;
          end
        end
        COMMIT: begin
          if (!strobe) begin
            state   <= LOW;
            low_cnt <= CNT_W'(1);
          end else begin
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          low_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mbc1_mapper.sv
// MBC1 cartridge memory bank controller.
// Decodes filtered bus writes into the bank/mode/RAM-enable registers and
// maps CPU addresses to ROM and external-RAM byte addresses.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus_A_s    : synchronized cartridge address
//   bus_D_in_s : synchronized cartridge write data
//   bus_nWR    : raw asynchronous write strobe (active low)
//   rom_addr   : registered mapped ROM byte address
//   ram_addr   : registered mapped external-RAM byte address
//   ram_sel    : registered external-RAM select
//   ram_we     : one-cycle RAM write pulse, coincident with the commit cycle
//   rom_bank   : low ROM bank register
//   bank_mode  : banking-mode register
module mbc1_mapper
  import mbc1_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned MIN_LOW     = 4,
  parameter int unsigned ROM_ADDR_W  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           bus_A_s,
  input  logic [7:0]            bus_D_in_s,
  input  logic                  bus_nWR,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [14:0]           ram_addr,
  output logic                  ram_sel,
  output logic                  ram_we,
  output logic [4:0]            rom_bank,
  output logic                  bank_mode
);

  logic       commit;
  logic [2:0] region;
  logic [1:0] bank_hi;
  logic       ram_en;
  logic [1:0] hi_sel;
  logic       unused_data_bits;

  assign region = bus_A_s[15:13];
  // bank_hi reaches the 0000-3FFF window and RAM only in mode 1
  assign hi_sel = bank_mode ? bank_hi : 2'b00;
  // D[7:5] carry no meaning for any MBC1 register
  assign unused_data_bits = ^bus_D_in_s[7:5];

  wr_strobe_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_LOW    (MIN_LOW)
  ) u_wr_filter (
    .clk    (clk),
    .reset  (reset),
    .bus_nwr(bus_nWR),
    .commit (commit)
  );

  // Register writes, using the address/data present in the commit cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_bank  <= 5'd1;
      bank_hi   <= 2'b00;
      bank_mode <= 1'b0;
      ram_en    <= 1'b0;
    end else if (commit) begin
      case (region)
        REG_RAMEN:   ram_en    <= (bus_D_in_s[3:0] == RAM_EN_KEY);
        REG_ROMBANK: rom_bank  <= (bus_D_in_s[4:0] == 5'd0) ? 5'd1 : bus_D_in_s[4:0];
        REG_BANKHI:  bank_hi   <= bus_D_in_s[1:0];
        REG_MODE:    bank_mode <= bus_D_in_s[0];
        default: ;
      endcase
    end
  end

  // Address mapping, one cycle behind bus_A_s
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      ram_addr <= '0;
      ram_sel  <= 1'b0;
    end else begin
      rom_addr <= ROM_ADDR_W'(bus_A_s[14] ? {bank_hi, rom_bank, bus_A_s[13:0]}
                                          : {hi_sel, 5'b00000, bus_A_s[13:0]});
      ram_addr <= {hi_sel, bus_A_s[12:0]};
      ram_sel  <= (region == REG_XRAM) && ram_en;
    end
  end

  // RAM writes change no register; the pulse is the commit cycle itself
  assign ram_we = commit && !reset && (region == REG_XRAM) && ram_en;

endmodule

// File: tb/tb_mbc1_mapper.sv
// Self-checking bench for mbc1_mapper: directed scenarios plus randomized
// writes/reads compared against an arithmetic model of the MBC1 rules.
module tb_mbc1_mapper;

  localparam int unsigned AW      = 21;
  localparam int unsigned MIN_LOW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   a;
  logic [7:0]    d;
  logic          nwr;
  logic [AW-1:0] rom_addr;
  logic [14:0]   ram_addr;
  logic          ram_sel;
  logic          ram_we;
  logic [4:0]    rom_bank;
  logic          bank_mode;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;

  // Model state
  int m_bank, m_hi, m_mode, m_en;

  mbc1_mapper #(
    .SYNC_STAGES(3),
    .MIN_LOW    (MIN_LOW),
    .ROM_ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_A_s   (a),
    .bus_D_in_s(d),
    .bus_nWR   (nwr),
    .rom_addr  (rom_addr),
    .ram_addr  (ram_addr),
    .ram_sel   (ram_sel),
    .ram_we    (ram_we),
    .rom_bank  (rom_bank),
    .bank_mode (bank_mode)
  );

  always #25 clk = ~clk;

  always @(negedge clk) if (ram_we === 1'b1) we_count = we_count + 1;

  task automatic model_reset();
    m_bank = 1; m_hi = 0; m_mode = 0; m_en = 0;
  endtask

  task automatic model_write(input int ad, input int dv);
    case (ad >> 13)
      0: m_en   = ((dv & 'hF) == 'hA) ? 1 : 0;
      1: m_bank = ((dv & 'h1F) == 0) ? 1 : (dv & 'h1F);
      2: m_hi   = dv & 3;
      3: m_mode = dv & 1;
      default: ;
    endcase
  endtask

  function automatic int exp_rom(input int ad);
    int bn;
    if (ad < 'h4000) bn = m_mode ? m_hi * 32 : 0;
    else             bn = m_hi * 32 + m_bank;
    return (bn * 'h4000 + (ad & 'h3FFF)) % (1 << AW);
  endfunction

  function automatic int exp_ram(input int ad);
    return (m_mode ? m_hi : 0) * 'h2000 + (ad & 'h1FFF);
  endfunction

  function automatic int exp_sel(input int ad);
    return (ad >= 'hA000 && ad <= 'hBFFF && m_en == 1) ? 1 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; nwr = 1'b1; a = 16'h0000; d = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Strobe held low for 'low' rising edges, then released with address/data held
  task automatic do_write(input int ad, input int dv, input int low);
    @(negedge clk);
    a = 16'(ad); d = 8'(dv); nwr = 1'b0;
    repeat (low) @(negedge clk);
    nwr = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_read(input int ad);
    @(negedge clk);
    a = 16'(ad);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; nwr = 1'b1; a = 16'hB000; d = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (rom_addr !== '0 || ram_addr !== '0 || ram_sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_addr rom=%h ram=%h sel=%b expected all zero", rom_addr, ram_addr, ram_sel);
    end
    checks++;
    if (rom_bank !== 5'd1 || bank_mode !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs rom_bank=%0d mode=%b we=%b expected 1/0/0", rom_bank, bank_mode, ram_we);
    end
    reset = 1'b0;
    model_reset();
    do_read('h4000);
    checks++;
    if (rom_addr !== 21'h04000) begin
      failures++;
      $display("FAIL reset_map4000 got=%h expected=%h", rom_addr, 21'h04000);
    end
    do_read('h0123);
    checks++;
    if (rom_addr !== 21'h00123) begin
      failures++;
      $display("FAIL reset_map0123 got=%h expected=%h", rom_addr, 21'h00123);
    end
  endtask

  task automatic test_rom_bank();
    do_reset();
    do_write('h2100, 'h00, 5);
    checks++;
    if (rom_bank !== 5'd1) begin
      failures++;
      $display("FAIL bank_zero_to_one got=%0d expected=1", rom_bank);
    end
    do_write('h2100, 'hE3, 5);
    checks++;
    if (rom_bank !== 5'd3) begin
      failures++;
      $display("FAIL bank_e3 got=%0d expected=3", rom_bank);
    end
    do_read('h5ABC);
    checks++;
    if (rom_addr !== 21'h0DABC) begin
      failures++;
      $display("FAIL bank_map5abc got=%h expected=%h", rom_addr, 21'h0DABC);
    end
  endtask

  task automatic test_glitch();
    int wc;
    do_reset();
    wc = we_count;
    do_write('h2000, 'h05, 2);
    checks++;
    if (rom_bank !== 5'd1 || we_count !== wc) begin
      failures++;
      $display("FAIL glitch2 rom_bank=%0d we=%0d expected 1 and %0d", rom_bank, we_count, wc);
    end
    do_write('h2000, 'h06, MIN_LOW - 1);
    checks++;
    if (rom_bank !== 5'd1) begin
      failures++;
      $display("FAIL glitch_short rom_bank=%0d expected=1", rom_bank);
    end
    do_write('h2000, 'h07, MIN_LOW);
    checks++;
    if (rom_bank !== 5'd7) begin
      failures++;
      $display("FAIL min_low_write rom_bank=%0d expected=7", rom_bank);
    end
  endtask

  task automatic test_ram_we();
    int wc;
    do_reset();
    do_write('h0000, 'h0A, 5);
    wc = we_count;
    do_write('hA010, 'h55, 5);
    checks++;
    if (we_count - wc !== 1) begin
      failures++;
      $display("FAIL ram_we_enabled pulses=%0d expected=1", we_count - wc);
    end
    do_read('hA010);
    checks++;
    if (ram_sel !== 1'b1) begin
      failures++;
      $display("FAIL ram_sel_enabled got=%b expected=1", ram_sel);
    end
    do_write('h0000, 'h00, 5);
    wc = we_count;
    do_write('hA010, 'h55, 5);
    checks++;
    if (we_count !== wc) begin
      failures++;
      $display("FAIL ram_we_disabled pulses=%0d expected=0", we_count - wc);
    end
  endtask

  task automatic test_mode1();
    do_reset();
    do_write('h4000, 'h02, 5);
    do_write('h6000, 'h01, 5);
    checks++;
    if (bank_mode !== 1'b1) begin
      failures++;
      $display("FAIL mode_set got=%b expected=1", bank_mode);
    end
    do_read('h0010);
    checks++;
    if (rom_addr !== 21'h100010) begin
      failures++;
      $display("FAIL mode1_rom got=%h expected=%h", rom_addr, 21'h100010);
    end
    do_read('hB004);
    checks++;
    if (ram_addr !== 15'h5004) begin
      failures++;
      $display("FAIL mode1_ram got=%h expected=%h", ram_addr, 15'h5004);
    end
  endtask

  task automatic test_reset_armed();
    int wc;
    do_reset();
    wc = we_count;
    @(negedge clk);
    a = 16'h2000; d = 8'h05; nwr = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    nwr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (12) @(negedge clk);
    checks++;
    if (rom_bank !== 5'd1 || we_count !== wc) begin
      failures++;
      $display("FAIL reset_armed rom_bank=%0d we=%0d expected 1 and %0d", rom_bank, we_count - wc, 0);
    end
  endtask

  task automatic test_random();
    int ad, dv, low, wc, exp_we, rd;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      ad  = int'($urandom_range(0, 7)) * 'h2000 + int'($urandom_range(0, 'h1FFF));
      dv  = int'($urandom_range(0, 255));
      if (ad < 'h2000 && $urandom_range(0, 1) == 1) dv = (dv & 'hF0) | 'hA;
      low = int'($urandom_range(1, 7));
      exp_we = (low >= int'(MIN_LOW)) ? exp_sel(ad) : 0;
      wc = we_count;
      do_write(ad, dv, low);
      if (low >= int'(MIN_LOW)) model_write(ad, dv);
      checks++;
      if (int'(rom_bank) !== m_bank || int'(bank_mode) !== m_mode) begin
        failures++;
        $display("FAIL rnd_regs i=%0d bank=%0d mode=%b expected %0d/%0d", i, rom_bank, bank_mode, m_bank, m_mode);
      end
      checks++;
      if (we_count - wc !== exp_we) begin
        failures++;
        $display("FAIL rnd_we i=%0d pulses=%0d expected=%0d", i, we_count - wc, exp_we);
      end
      rd = ($urandom_range(0, 2) == 0) ? 'hA000 + int'($urandom_range(0, 'h1FFF))
                                       : int'($urandom_range(0, 'h7FFF));
      do_read(rd);
      if (rd < 'h8000) begin
        checks++;
        if (int'(rom_addr) !== exp_rom(rd)) begin
          failures++;
          $display("FAIL rnd_rom i=%0d a=%h got=%h expected=%h", i, rd, rom_addr, exp_rom(rd));
        end
      end
      checks++;
      if (int'(ram_addr) !== exp_ram(rd) || int'(ram_sel) !== exp_sel(rd)) begin
        failures++;
        $display("FAIL rnd_ram i=%0d a=%h got=%h/%b expected=%h/%0d", i, rd, ram_addr, ram_sel, exp_ram(rd), exp_sel(rd));
      end
    end
  endtask

  initial begin
    reset = 1'b1; nwr = 1'b1; a = 16'h0000; d = 8'h00;
    model_reset();
    test_reset();
    test_rom_bank();
    test_glitch();
    test_ram_we();
    test_mode1();
    test_reset_armed();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
